// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store sequencer: ALU load/store ops, FSM states, access sizes.
package lsu_ctrl_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_OP_LB  = 4'h0,
    ALU_OP_LH  = 4'h1,
    ALU_OP_LW  = 4'h2,
    ALU_OP_LBU = 4'h4,
    ALU_OP_LHU = 4'h5,
    ALU_OP_SB  = 4'h8,
    ALU_OP_SH  = 4'h9,
    ALU_OP_SW  = 4'hA
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_RESP
  } lsu_state_e;

  localparam logic [2:0] SIZE_NONE = 3'd0;
  localparam logic [2:0] SIZE_B    = 3'd1;
  localparam logic [2:0] SIZE_H    = 3'd2;
  localparam logic [2:0] SIZE_W    = 3'd4;

  // Unsupported ops decode to SIZE_NONE, which doubles as the legality test.
  function automatic logic [2:0] op_size(input logic [ALU_OP_W-1:0] op);
    case (op)
      ALU_OP_LB, ALU_OP_LBU, ALU_OP_SB: op_size = SIZE_B;
      ALU_OP_LH, ALU_OP_LHU, ALU_OP_SH: op_size = SIZE_H;
      ALU_OP_LW, ALU_OP_SW:             op_size = SIZE_W;
      default:                          op_size = SIZE_NONE;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [ALU_OP_W-1:0] op);
    op_is_store = (op == ALU_OP_SB) || (op == ALU_OP_SH) || (op == ALU_OP_SW);
  endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// lsu_align: combinational store lane shift / strobe mask and load merge with sign/zero extension.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [1:0]          off_i,
  input  logic [31:0]         wdata_i,
  input  logic [31:0]         beat0_i,
  input  logic [31:0]         beat1_i,
  output logic [63:0]         lanes_o,
  output logic [7:0]          mask_o,
  output logic [31:0]         ldata_o
);

  logic [3:0]  size_mask;
  logic [31:0] merged;

  always_comb begin
    case (op_size(op_i))
      SIZE_B:  size_mask = 4'b0001;
      SIZE_H:  size_mask = 4'b0011;
      SIZE_W:  size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
    lanes_o = {32'h0, wdata_i} << {off_i, 3'b000};
    mask_o  = {4'h0, size_mask} << off_i;
    merged  = 32'({beat1_i, beat0_i} >> {off_i, 3'b000});
    case (op_i)
      ALU_OP_LB:  ldata_o = {{24{merged[7]}}, merged[7:0]};
      ALU_OP_LH:  ldata_o = {{16{merged[15]}}, merged[15:0]};
      ALU_OP_LW:  ldata_o = merged;
      ALU_OP_LBU: ldata_o = {24'h0, merged[7:0]};
      ALU_OP_LHU: ldata_o = {16'h0, merged[15:0]};
      default:    ldata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer FSM. Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses
// into two beats; otherwise crossing accesses return an error with no memory beat.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ALU_OP_W-1:0] req_op_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic                mem_wen_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [3:0]          mem_wstrb_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [DATA_W-1:0]   resp_data_o,
  output logic                resp_err_o
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  lsu_state_e          state_q, state_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   beat0_q, beat0_d;
  logic [DATA_W-1:0]   beat1_q, beat1_d;
  logic                cross_q, cross_d;
  logic                err_q, err_d;
  logic                ready_q, mem_valid_q, resp_valid_q;

  logic [63:0]         lanes;
  logic [7:0]          mask;
  logic [31:0]         ldata;
  logic                beat_sel;
  logic                is_store;
  logic [ADDR_W-1:0]   base_addr;

  lsu_align u_align (
    .op_i    (op_q),
    .off_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .beat0_i (beat0_q),
    .beat1_i (beat1_q),
    .lanes_o (lanes),
    .mask_o  (mask),
    .ldata_o (ldata)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    beat0_d = beat0_q;
    beat1_d = beat1_q;
    cross_d = cross_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          op_d    = req_op_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          beat0_d = '0;
          beat1_d = '0;
          cross_d = ({1'b0, req_addr_i[1:0]} + op_size(req_op_i)) > 3'd4;
          err_d   = (op_size(req_op_i) == SIZE_NONE) || (cross_d && !SplitEn);
          state_d = err_d ? ST_RESP : ST_REQ0;
        end
      end
      ST_REQ0:  if (mem_ready_i) state_d = ST_WAIT0;
      ST_WAIT0: begin
        if (mem_rvalid_i) begin
          beat0_d = mem_rdata_i;
          state_d = (cross_q && SplitEn) ? ST_REQ1 : ST_RESP;
        end
      end
      ST_REQ1:  if (mem_ready_i) state_d = ST_WAIT1;
      ST_WAIT1: begin
        if (mem_rvalid_i) begin
          beat1_d = mem_rdata_i;
          state_d = ST_RESP;
        end
      end
      ST_RESP:  if (resp_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are registered off the next state so they drop to 0 under reset
  // and req_ready_o only rises on the first edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      beat0_q      <= '0;
      beat1_q      <= '0;
      cross_q      <= 1'b0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
      mem_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      beat0_q      <= beat0_d;
      beat1_q      <= beat1_d;
      cross_q      <= cross_d;
      err_q        <= err_d;
      ready_q      <= (state_d == ST_IDLE);
      mem_valid_q  <= (state_d == ST_REQ0) || (state_d == ST_REQ1);
      resp_valid_q <= (state_d == ST_RESP);
    end
  end

  assign beat_sel  = (state_q == ST_REQ1);
  assign is_store  = op_is_store(op_q);
  assign base_addr = {addr_q[ADDR_W-1:2], 2'b00};

  assign req_ready_o  = ready_q;
  assign mem_valid_o  = mem_valid_q;
  assign mem_wen_o    = mem_valid_q & is_store;
  assign mem_addr_o   = !mem_valid_q ? '0 : (beat_sel ? base_addr + ADDR_W'(4) : base_addr);
  assign mem_wstrb_o  = !mem_wen_o ? '0 : (beat_sel ? mask[7:4] : mask[3:0]);
  assign mem_wdata_o  = !mem_wen_o ? '0 : (beat_sel ? lanes[63:32] : lanes[31:0]);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_valid_q & err_q;
  assign resp_data_o  = (resp_valid_q && !err_q && !is_store) ? ldata : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed vector bench for lsu_ctrl; split-dependent expectations follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_op_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_data_o;
  logic        resp_err_o;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .mem_valid_o  (mem_valid_o),
    .mem_ready_i  (mem_ready_i),
    .mem_wen_o    (mem_wen_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_err_o   (resp_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, wdata, w0, w1;
    int          mstall, rstall;
    logic        e_err;
    logic [31:0] e_data;
    int          e_cyc, e_beats;
    logic [31:0] e_a0;
    logic [3:0]  e_s0;
    logic [31:0] e_d0;
    logic        e_wen;
    logic [31:0] e_a1;
    logic [3:0]  e_s1;
    logic [31:0] e_d1;
  } vec_t;

  vec_t vecs[13];
  int   checks = 0;
  int   errors = 0;
  int   cur_vec = -1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h expected %h", name, cur_vec, act, exp);
    end
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_ready", {31'h0, req_ready_o}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc = 0, nb = 0, msc = 0, rsc = 0, rcyc = -1, unstable = 0, busy = 0, pidx = 0;
    bit pend = 0, resp_hs = 0, have_resp = 0, snap_ok = 0;
    logic [31:0] ra[2], rd[2], rdata_c, snap_a, snap_d;
    logic [3:0]  rs[2], snap_s;
    logic        rw[2], rerr_c, snap_w;
    ra = '{0, 0}; rd = '{0, 0}; rs = '{0, 0}; rw = '{0, 0};
    rdata_c = '0; rerr_c = 1'b0;
    snap_a = '0; snap_d = '0; snap_s = '0; snap_w = 1'b0;
    wait_ready();
    req_valid_i = 1'b1; req_op_i = v.op; req_addr_i = v.addr; req_wdata_i = v.wdata;
    while (cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      req_valid_i = 1'b0; mem_ready_i = 1'b0; resp_ready_i = 1'b0;
      mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      if (resp_hs) break;
      if (pend) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = (pidx == 0) ? v.w0 : v.w1;
        pend = 1'b0;
      end
      if (req_ready_o) busy++;
      if (mem_valid_o) begin
        if (!snap_ok) begin
          snap_a = mem_addr_o; snap_s = mem_wstrb_o; snap_d = mem_wdata_o; snap_w = mem_wen_o;
          snap_ok = 1'b1;
        end else if (mem_addr_o !== snap_a || mem_wstrb_o !== snap_s ||
                     mem_wdata_o !== snap_d || mem_wen_o !== snap_w) begin
          unstable++;
        end
        if (msc >= v.mstall) begin
          mem_ready_i = 1'b1;
          if (nb < 2) begin
            ra[nb] = mem_addr_o; rs[nb] = mem_wstrb_o; rd[nb] = mem_wdata_o; rw[nb] = mem_wen_o;
          end
          pidx = nb; nb++; pend = 1'b1; snap_ok = 1'b0;
        end else begin
          msc++;
        end
      end
      if (resp_valid_o) begin
        if (!have_resp) begin
          rcyc = cyc; rdata_c = resp_data_o; rerr_c = resp_err_o; have_resp = 1'b1;
        end else if (resp_data_o !== rdata_c || resp_err_o !== rerr_c) begin
          unstable++;
        end
        if (rsc >= v.rstall) begin
          resp_ready_i = 1'b1; resp_hs = 1'b1;
        end else begin
          rsc++;
        end
      end
    end
    chk("resp_handshake", {31'h0, resp_hs}, 32'd1);
    chk("resp_err", {31'h0, rerr_c}, {31'h0, v.e_err});
    chk("resp_data", rdata_c, v.e_data);
    chk("resp_cycle", rcyc, v.e_cyc);
    chk("beat_count", nb, v.e_beats);
    chk("stable", unstable, 0);
    chk("ready_low_busy", busy, 0);
    chk("resp_once", {31'h0, resp_valid_o}, 32'd0);
    chk("ready_after_resp", {31'h0, req_ready_o}, 32'd1);
    if (nb >= 1 && v.e_beats >= 1) begin
      chk("beat0_addr", ra[0], v.e_a0);
      chk("beat0_wstrb", {28'h0, rs[0]}, {28'h0, v.e_s0});
      chk("beat0_wdata", rd[0], v.e_d0);
      chk("beat0_wen", {31'h0, rw[0]}, {31'h0, v.e_wen});
    end
    if (nb >= 2 && v.e_beats >= 2) begin
      chk("beat1_addr", ra[1], v.e_a1);
      chk("beat1_wstrb", {28'h0, rs[1]}, {28'h0, v.e_s1});
      chk("beat1_wdata", rd[1], v.e_d1);
      chk("beat1_wen", {31'h0, rw[1]}, {31'h0, v.e_wen});
    end
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {req_ready_o, mem_valid_o, mem_wen_o, resp_valid_o, resp_err_o, mem_wstrb_o} , 32'd0);
    chk({name, "_bus"}, mem_addr_o | mem_wdata_o | resp_data_o, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid_i = 1'b0; req_op_i = '0; req_addr_i = '0; req_wdata_i = '0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; resp_ready_i = 1'b0;

    //          op          addr          wdata         w0            w1            ms rs err data          cyc bt a0            s0    d0            wen a1    s1    d1
    vecs[0]  = '{ALU_OP_LW,  32'h00001000, 32'h0,        32'hDEADBEEF, 32'h0,        0, 0, 0, 32'hDEADBEEF, 3, 1, 32'h00001000, 4'h0, 32'h0,        0, 32'h0, 4'h0, 32'h0};
    vecs[1]  = '{ALU_OP_LB,  32'h00001003, 32'h0,        32'h80FF00AA, 32'h0,        0, 0, 0, 32'hFFFFFF80, 3, 1, 32'h00001000, 4'h0, 32'h0,        0, 32'h0, 4'h0, 32'h0};
    vecs[2]  = '{ALU_OP_LBU, 32'h00001003, 32'h0,        32'h80FF00AA, 32'h0,        0, 0, 0, 32'h00000080, 3, 1, 32'h00001000, 4'h0, 32'h0,        0, 32'h0, 4'h0, 32'h0};
    vecs[3]  = '{ALU_OP_SH,  32'h00002002, 32'h00001234, 32'h0,        32'h0,        0, 0, 0, 32'h0,        3, 1, 32'h00002000, 4'hC, 32'h12340000, 1, 32'h0, 4'h0, 32'h0};
    vecs[5]  = '{4'hF,       32'h00000010, 32'h0,        32'h0,        32'h0,        0, 0, 1, 32'h0,        1, 0, 32'h0,        4'h0, 32'h0,        0, 32'h0, 4'h0, 32'h0};
    vecs[6]  = '{ALU_OP_LH,  32'h00004002, 32'h0,        32'h80010000, 32'h0,        0, 0, 0, 32'hFFFF8001, 3, 1, 32'h00004000, 4'h0, 32'h0,        0, 32'h0, 4'h0, 32'h0};
    vecs[7]  = '{ALU_OP_LHU, 32'h00004001, 32'h0,        32'h00ABCD00, 32'h0,        0, 0, 0, 32'h0000ABCD, 3, 1, 32'h00004000, 4'h0, 32'h0,        0, 32'h0, 4'h0, 32'h0};
    vecs[8]  = '{ALU_OP_SB,  32'h00005001, 32'h000000A5, 32'hFFFFFFFF, 32'h0,        0, 0, 0, 32'h0,        3, 1, 32'h00005000, 4'h2, 32'h0000A500, 1, 32'h0, 4'h0, 32'h0};
    vecs[9]  = '{ALU_OP_SW,  32'h00006000, 32'hCAFEF00D, 32'h0,        32'h0,        0, 0, 0, 32'h0,        3, 1, 32'h00006000, 4'hF, 32'hCAFEF00D, 1, 32'h0, 4'h0, 32'h0};
    vecs[11] = '{ALU_OP_LW,  32'h00008000, 32'h0,        32'h0BADF00D, 32'h0,        5, 3, 0, 32'h0BADF00D, 8, 1, 32'h00008000, 4'h0, 32'h0,        0, 32'h0, 4'h0, 32'h0};
    if (SPLIT) begin
      vecs[4]  = '{ALU_OP_LW, 32'h00003003, 32'h0,        32'h11223344, 32'h55667788, 0, 0, 0, 32'h66778811, 5, 2, 32'h00003000, 4'h0, 32'h0,        0, 32'h00003004, 4'h0, 32'h0};
      vecs[10] = '{ALU_OP_SW, 32'h00007002, 32'h11223344, 32'h0,        32'h0,        0, 0, 0, 32'h0,        5, 2, 32'h00007000, 4'hC, 32'h33440000, 1, 32'h00007004, 4'h3, 32'h00001122};
      vecs[12] = '{ALU_OP_LH, 32'hFFFFFFFF, 32'h0,        32'hAB000000, 32'h000000CD, 0, 0, 0, 32'hFFFFCDAB, 5, 2, 32'hFFFFFFFC, 4'h0, 32'h0,        0, 32'h00000000, 4'h0, 32'h0};
    end else begin
      vecs[4]  = '{ALU_OP_LW, 32'h00003003, 32'h0,        32'h11223344, 32'h55667788, 0, 0, 1, 32'h0,        1, 0, 32'h0,        4'h0, 32'h0,        0, 32'h0, 4'h0, 32'h0};
      vecs[10] = '{ALU_OP_SW, 32'h00007002, 32'h11223344, 32'h0,        32'h0,        0, 0, 1, 32'h0,        1, 0, 32'h0,        4'h0, 32'h0,        0, 32'h0, 4'h0, 32'h0};
      vecs[12] = '{ALU_OP_LH, 32'hFFFFFFFF, 32'h0,        32'hAB000000, 32'h000000CD, 0, 0, 1, 32'h0,        1, 0, 32'h0,        4'h0, 32'h0,        0, 32'h0, 4'h0, 32'h0};
    end

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst = 1'b0;
    chk("ready_before_edge", {31'h0, req_ready_o}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_reset", {31'h0, req_ready_o}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // Async reset while a beat is being offered (REQ0): mem_valid_o must drop before any edge.
    cur_vec = 100;
    wait_ready();
    req_valid_i = 1'b1; req_op_i = ALU_OP_SW; req_addr_i = 32'h9000; req_wdata_i = 32'h5A5A5A5A;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("req0_valid", {31'h0, mem_valid_o}, 32'd1);
    chk("req0_wstrb", {28'h0, mem_wstrb_o}, 32'hF);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst_req0");
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset during WAIT0: no response afterwards, then a normal transaction.
    cur_vec = 101;
    @(posedge clk); #1;
    wait_ready();
    req_valid_i = 1'b1; req_op_i = ALU_OP_LW; req_addr_i = 32'h9000;
    @(posedge clk); #1;
    req_valid_i = 1'b0; mem_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    chk("wait0_no_valid", {31'h0, mem_valid_o}, 32'd0);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst_wait0");
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
    chk("ready_low_at_release", {31'h0, req_ready_o}, 32'd0);
    begin
      int stray = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (resp_valid_o || mem_valid_o) stray++;
      end
      chk("no_resp_after_abort", stray, 0);
    end
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    chk("ready_after_abort", {31'h0, req_ready_o}, 32'd1);
    cur_vec = 0;
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
